// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store initiator.
// State encoding, RV32I funct3 size/sign codes and request legality checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we)
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        return ok;
    endfunction

    // Halfwords need an even byte address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if ((funct3 == F3_H) || (funct3 == F3_HU))
            mis = off[0];
        else if (funct3 == F3_W)
            mis = (off != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store initiator (purely combinational).
// Load path: picks the addressed byte/halfword out of a memory word and extends it.
// Store path: merges sub-word store data into the previously read word.
// Halfword selection uses off[1] only and word accesses ignore the offset,
// so misaligned requests that reach here are silently aligned.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ld_word,
    input  logic [DATA_W-1:0] st_old,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_word
);

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0] sb;
        sb = b;
        return sgn ? DATA_W'(sb) : DATA_W'(b);
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        sh = h;
        return sgn ? DATA_W'(sh) : DATA_W'(h);
    endfunction

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Load extract and extension
    always_comb begin
        lane_b  = ld_word[{off, 3'b000} +: 8];
        lane_h  = ld_word[{off[1], 4'b0000} +: 16];
        ld_data = '0;
        case (funct3)
            F3_B:    ld_data = ext_byte(lane_b, 1'b1);
            F3_BU:   ld_data = ext_byte(lane_b, 1'b0);
            F3_H:    ld_data = ext_half(lane_h, 1'b1);
            F3_HU:   ld_data = ext_half(lane_h, 1'b0);
            F3_W:    ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

    // Store merge into the word read back from memory
    always_comb begin
        st_word = st_old;
        case (funct3)
            F3_B:    st_word[{off, 3'b000} +: 8]     = st_wdata[7:0];
            F3_H:    st_word[{off[1], 4'b0000} +: 16] = st_wdata[15:0];
            F3_W:    st_word = st_wdata;
            default: st_word = st_old;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and word-addressed dMem.
// Sub-word stores are done as read-modify-write; loads are extended in lsu_align.
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, misaligned halfword
// and word accesses complete with rsp_err and never touch memory; otherwise
// they are forced to natural alignment.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              memRd,
    output logic              memWrt,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut
);

    lsu_state_e state_q, state_d;
    logic       err_p0, err_d;
    logic       accept;
    logic       req_err;

    logic              we_p0;
    logic [2:0]        f3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rdword_p1;

    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

    // Request classification at acceptance time
    always_comb begin
`ifdef MISALIGN_TRAP_EN
        req_err = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
        req_err = !is_legal(req_we, req_funct3);
`endif
    end

    // Control state: FSM state and the error flag of the transaction in flight
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            err_p0  <= 1'b0;
        end else begin
            state_q <= state_d;
            err_p0  <= err_d;
        end
    end

    // ---- stage p0: request captured on acceptance ----
    // Request payload latch; unreset, only consumed outside IDLE
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= req_we;
            f3_p0    <= req_funct3;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // ---- stage p1: memory word captured during RD ----
    // Read-word capture feeding both load extract and store merge
    always_ff @(posedge clk) begin
        if (state_q == RD)
            rdword_p1 <= memDataOut;
    end

    // Next-state and phase strobes
    always_comb begin
        state_d   = state_q;
        err_d     = err_p0;
        accept    = 1'b0;
        req_ready = 1'b0;
        memRd     = 1'b0;
        memWrt    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    err_d  = req_err;
                    if (req_err)
                        state_d = RSP;
                    else if (req_we && (req_funct3 == F3_W))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                memRd   = 1'b1;
                state_d = we_p0 ? WR : RSP;
            end
            WR: begin
                memWrt  = 1'b1;
                state_d = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .ld_word  (rdword_p1),
        .st_old   (rdword_p1),
        .st_wdata (wdata_p0),
        .off      (addr_p0[1:0]),
        .funct3   (f3_p0),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    // Outputs derived from registered state only; zero outside their phase
    always_comb begin
        memAddr   = (memRd || memWrt) ? {2'b00, addr_p0[ADDR_W-1:2]} : '0;
        memDataIn = memWrt ? st_word : '0;
        rsp_rdata = (rsp_valid && !we_p0 && !err_p0) ? ld_data : '0;
        rsp_err   = rsp_valid && err_p0;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed vector table, hand-written corner
// sequences (misaligned word load, ignored requests, reset mid-write) and
// randomized traffic checked against a byte-array reference model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        memRd;
    logic        memWrt;
    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic [31:0] memDataOut;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .memRd      (memRd),
        .memWrt     (memWrt),
        .memAddr    (memAddr),
        .memDataIn  (memDataIn),
        .memDataOut (memDataOut)
    );

    // dMem: 256 words, combinational read, write committed on the clock edge
    logic [31:0] mem [0:255];
    assign memDataOut = mem[memAddr[7:0]];
    always @(posedge clk) begin
        if (memWrt) mem[memAddr[7:0]] <= memDataIn;
    end

    // Reference byte memory (1 KB) for the random phase
    logic [7:0] rmem [0:1023];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic err, input int lat, input int nrd, input int nwr);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and observe it until rsp_valid (bounded)
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                           output int lat, output int nrd, output int nwr,
                           output logic [31:0] maddr, output int rdy_bad);
        rdata = 32'h0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; maddr = 32'h0; rdy_bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        if (!req_ready) rdy_bad++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (memRd)  begin nrd++; maddr = memAddr; end
            if (memWrt) begin nwr++; maddr = memAddr; end
            if (memRd && memWrt) rdy_bad++;
            if (rsp_valid) begin
                lat = c; rdata = rsp_rdata; err = rsp_err;
                break;
            end
            if (req_ready) rdy_bad++;
        end
    endtask

    task automatic do_check(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] e_rdata, input logic e_err,
                            input int e_lat, input int e_nrd, input int e_nwr);
        logic [31:0] rd, ma;
        logic e;
        int lat, nrd, nwr, rb;
        run_req(we, f3, addr, wdata, rd, e, lat, nrd, nwr, ma, rb);
        if (lat == 0) begin
            n_vec++; n_bad++;
            $display("FAIL %s timeout: no rsp_valid within 10 cycles", tag);
        end else begin
            chk({tag, " rdata"}, rd, e_rdata);
            chk({tag, " err"}, 32'(e), 32'(e_err));
            chk({tag, " latency"}, lat, e_lat);
            chk({tag, " memRd count"}, nrd, e_nrd);
            chk({tag, " memWrt count"}, nwr, e_nwr);
            chk({tag, " memAddr"}, ma, (e_nrd + e_nwr > 0) ? (addr >> 2) : 32'h0);
            chk({tag, " ready/strobe"}, rb, 0);
        end
    endtask

    // Specification-level model over byte memory
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic e,
                         output int lat, output int nrd, output int nwr);
        int sz, base;
        logic legal, mis;
        logic [31:0] v;
        legal = we ? (f3 < 3'd3) : (f3 != 3'd3 && f3 < 3'd6);
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis   = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
        e     = !legal;
`ifdef MISALIGN_TRAP_EN
        if (mis) e = 1'b1;
`else
        if (mis) e = e;
`endif
        rd = 32'h0; nrd = 0; nwr = 0; lat = 1;
        if (!e) begin
            base = (int'(addr[9:0]) / sz) * sz;
            if (!we) begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) v = v | (32'(rmem[base + i]) << (8 * i));
                if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v; lat = 2; nrd = 1;
            end else begin
                for (int i = 0; i < sz; i++) rmem[base + i] = wdata[8 * i +: 8];
                lat = (sz == 4) ? 2 : 3;
                nrd = (sz < 4) ? 1 : 0;
                nwr = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, ma, w, a;
        logic e, we;
        logic [2:0] f3;
        int lat, nrd, nwr, rb, bad_cyc;

        rst_ = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;

        // Reset state and ten idle cycles
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset outputs", {memRd, memWrt, rsp_valid, rsp_err} | memAddr | memDataIn | rsp_rdata, 32'h0);
        rst_ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle strobes", {27'h0, memRd, memWrt, rsp_valid, rsp_err, req_ready}, 32'h1);
            chk("idle buses", memAddr | memDataIn | rsp_rdata, 32'h0);
        end

        // Directed vectors
        tbl[0]  = mkv(1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1);
        tbl[1]  = mkv(0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0);
        tbl[2]  = mkv(1, 3'd2, 32'h20, 32'h8070F0FF, 32'h0,        0, 2, 0, 1);
        tbl[3]  = mkv(0, 3'd0, 32'h21, 32'h0,        32'hFFFFFFF0, 0, 2, 1, 0);
        tbl[4]  = mkv(0, 3'd4, 32'h21, 32'h0,        32'h000000F0, 0, 2, 1, 0);
        tbl[5]  = mkv(0, 3'd1, 32'h22, 32'h0,        32'hFFFF8070, 0, 2, 1, 0);
        tbl[6]  = mkv(0, 3'd5, 32'h22, 32'h0,        32'h00008070, 0, 2, 1, 0);
        tbl[7]  = mkv(1, 3'd2, 32'h30, 32'h11223344, 32'h0,        0, 2, 0, 1);
        tbl[8]  = mkv(1, 3'd0, 32'h32, 32'h000000AA, 32'h0,        0, 3, 1, 1);
        tbl[9]  = mkv(0, 3'd2, 32'h30, 32'h0,        32'h11AA3344, 0, 2, 1, 0);
        tbl[10] = mkv(1, 3'd1, 32'h30, 32'h0000BBCC, 32'h0,        0, 3, 1, 1);
        tbl[11] = mkv(0, 3'd2, 32'h30, 32'h0,        32'h11AABBCC, 0, 2, 1, 0);
        tbl[12] = mkv(0, 3'd3, 32'h10, 32'h0,        32'h0,        1, 1, 0, 0);
        tbl[13] = mkv(1, 3'd3, 32'h10, 32'h12345678, 32'h0,        1, 1, 0, 0);
        tbl[14] = mkv(0, 3'd6, 32'h10, 32'h0,        32'h0,        1, 1, 0, 0);
        tbl[15] = mkv(1, 3'd4, 32'h10, 32'h12345678, 32'h0,        1, 1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            do_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                     tbl[i].rdata, tbl[i].err, tbl[i].lat, tbl[i].nrd, tbl[i].nwr);
        end
        chk("sw memory word", mem[4], 32'hDEADBEEF);

        // Misaligned word load
`ifdef MISALIGN_TRAP_EN
        do_check("lw 0x13", 1'b0, 3'd2, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
        do_check("lw 0x13", 1'b0, 3'd2, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);
`endif

        // Requests presented while busy are ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
        @(posedge clk);
        #1 req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        bad_cyc = 0;
        @(negedge clk);
        chk("busy req_ready", 32'(req_ready), 32'h0);
        if (memWrt) bad_cyc++;
        @(negedge clk);
        chk("busy rsp_valid", 32'(rsp_valid), 32'h1);
        chk("busy rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        if (memWrt) bad_cyc++;
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy no write", bad_cyc, 0);
        do_check("busy after", 1'b0, 3'd2, 32'h20, 32'h0, 32'h8070F0FF, 1'b0, 2, 1, 0);

        // Reset asserted in the middle of a write phase
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("midwr memWrt before", 32'(memWrt), 32'h1);
        rst_ = 1'b0;
        #1;
        chk("midwr memWrt after", 32'(memWrt), 32'h0);
        chk("midwr req_ready", 32'(req_ready), 32'h1);
        bad_cyc = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid || memWrt || memRd) bad_cyc++;
        end
        rst_ = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) bad_cyc++;
        end
        chk("midwr quiet", bad_cyc, 0);
        do_check("midwr word kept", 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

        // Random phase: fill memory, then mixed traffic against the model
        for (int wi = 0; wi < 256; wi++) begin
            w = $urandom;
            model(1'b1, 3'd2, 32'(wi * 4), w, rd, e, lat, nrd, nwr);
            do_check("fill", 1'b1, 3'd2, 32'(wi * 4), w, rd, e, lat, nrd, nwr);
        end
        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            w  = $urandom;
            model(we, f3, a, w, rd, e, lat, nrd, nwr);
            do_check($sformatf("rnd%0d", k), we, f3, a, w, rd, e, lat, nrd, nwr);
        end
        @(negedge clk);
        for (int wi = 0; wi < 256; wi++) begin
            chk($sformatf("final word %0d", wi), mem[wi],
                {rmem[wi * 4 + 3], rmem[wi * 4 + 2], rmem[wi * 4 + 1], rmem[wi * 4]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
